// File: rtl/cache_pkg.sv
// cache_pkg: default geometry, derived address field widths and controller states
package cache_pkg;
    localparam int NUM_LINES_D      = 4;
    localparam int WORDS_PER_LINE_D = 4;
    localparam int MEM_WAIT_D       = 2;
    localparam int ADDR_W           = 10;
    localparam int WORD_W           = $clog2(WORDS_PER_LINE_D);
    localparam int INDEX_W          = $clog2(NUM_LINES_D);
    localparam int TAG_W            = ADDR_W - 2 - WORD_W - INDEX_W;
    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: per-line valid/dirty/tag/data arrays, one read port and one write port
module cache_line_store
    import cache_pkg::*;
#(
    parameter int NUM_LINES      = NUM_LINES_D,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_D,
    parameter int TAG_BITS       = TAG_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(NUM_LINES)-1:0]      r_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] r_word,
    output logic                              r_valid,
    output logic                              r_dirty,
    output logic [TAG_BITS-1:0]               r_tag,
    output logic [31:0]                       r_data,
    input  logic                              w_en,
    input  logic                              w_dirty,
    input  logic                              w_fill,
    input  logic [$clog2(NUM_LINES)-1:0]      w_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] w_word,
    input  logic [31:0]                       w_data,
    input  logic [TAG_BITS-1:0]               w_tag
);
    logic [NUM_LINES-1:0] valid, dirty;
    logic [TAG_BITS-1:0]  tag  [NUM_LINES];
    logic [31:0]          data [NUM_LINES][WORDS_PER_LINE];

    assign r_valid = valid[r_index];
    assign r_dirty = dirty[r_index];
    assign r_tag   = tag[r_index];
    assign r_data  = data[r_index][r_word];

    // a fill completes the line: valid with the new tag and clean
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            valid <= '0;
            dirty <= '0;
            for (int i = 0; i < NUM_LINES; i++) tag[i] <= '0;
        end else if (w_fill) begin
            valid[w_index] <= 1'b1;
            dirty[w_index] <= 1'b0;
            tag[w_index]   <= w_tag;
        end else if (w_dirty)
            dirty[w_index] <= 1'b1;

    always_ff @(posedge clk)
        if (w_en) data[w_index][w_word] <= w_data;
endmodule

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped write-back/write-allocate cache between a CPU word port and 1 KiB memory
module cache_controller
    import cache_pkg::*;
#(
    parameter int NUM_LINES      = NUM_LINES_D,
    parameter int WORDS_PER_LINE = WORDS_PER_LINE_D,
    parameter int MEM_WAIT       = MEM_WAIT_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              read_write_mem,
    output logic [ADDR_W-1:0] address_mem,
    output logic [31:0]       write_data_mem,
    input  logic [31:0]       read_data_mem,
    input  logic              Done
);
    localparam int WW = $clog2(WORDS_PER_LINE);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = ADDR_W - 2 - WW - IW;
    localparam int CW = $clog2(MEM_WAIT + 2);

    state_t            state, state_n;
    logic              rw_q, done_s1, done_s2;
    logic [ADDR_W-1:2] addr_q;
    logic [31:0]       wdata_q, r_data, w_data;
    logic [WW-1:0]     word_cnt, word_n, r_word, w_word;
    logic [CW-1:0]     wait_cnt;
    logic [TW-1:0]     r_tag, req_tag;
    logic [IW-1:0]     req_index;
    logic [ADDR_W-1:0] launch_addr;
    logic              r_valid, r_dirty, hit, step, last, launch, launch_rw;
    logic              w_en, w_dirty, w_fill, unused_ok;

    assign unused_ok   = ^cpu_addr[1:0];
    assign req_tag     = addr_q[ADDR_W-1 -: TW];
    assign req_index   = addr_q[2+WW +: IW];
    assign hit         = r_valid && r_tag == req_tag;
    assign step        = wait_cnt == CW'(MEM_WAIT) && done_s2;
    assign last        = word_cnt == WW'(WORDS_PER_LINE - 1);
    assign word_n      = state == COMPARE ? '0 : word_cnt + WW'(1);
    assign r_word      = state == COMPARE && hit ? addr_q[2 +: WW] : word_n;
    assign launch_addr = {launch_rw ? r_tag : req_tag, req_index, word_n, 2'b00};

    cache_line_store #(
        .NUM_LINES(NUM_LINES), .WORDS_PER_LINE(WORDS_PER_LINE), .TAG_BITS(TW)
    ) u_store (
        .clk(clk), .rst(rst),
        .r_index(req_index), .r_word(r_word), .r_valid(r_valid), .r_dirty(r_dirty),
        .r_tag(r_tag), .r_data(r_data),
        .w_en(w_en), .w_dirty(w_dirty), .w_fill(w_fill), .w_index(req_index),
        .w_word(w_word), .w_data(w_data), .w_tag(req_tag)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n   = state;
        cpu_done  = 1'b0;
        cpu_rdata = '0;
        launch    = 1'b0;
        launch_rw = 1'b0;
        w_en      = 1'b0;
        w_dirty   = 1'b0;
        w_fill    = 1'b0;
        w_word    = addr_q[2 +: WW];
        w_data    = wdata_q;
        case (state)
            IDLE: state_n = cpu_req ? COMPARE : IDLE;
            COMPARE: begin
                if (hit) begin
                    cpu_done  = 1'b1;
                    cpu_rdata = rw_q ? '0 : r_data;
                    w_en      = rw_q;
                    w_dirty   = rw_q;
                    state_n   = IDLE;
                end else begin
                    launch    = 1'b1;
                    launch_rw = r_valid && r_dirty;
                    state_n   = launch_rw ? WRITEBACK : ALLOCATE;
                end
            end
            // the last victim word hands straight over to the first fill read
            WRITEBACK: begin
                launch    = step;
                launch_rw = !last;
                state_n   = step && last ? ALLOCATE : WRITEBACK;
            end
            ALLOCATE: begin
                w_en    = step;
                w_fill  = step && last;
                w_word  = word_cnt;
                w_data  = read_data_mem;
                launch  = step && !last;
                state_n = step && last ? COMPARE : ALLOCATE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            {done_s2, done_s1} <= '0;
            rw_q               <= 1'b0;
            addr_q             <= '0;
            wdata_q            <= '0;
            word_cnt           <= '0;
            wait_cnt           <= '0;
            read_write_mem     <= 1'b0;
            address_mem        <= '0;
            write_data_mem     <= '0;
        end else begin
            {done_s2, done_s1} <= {done_s1, Done};
            if (state == IDLE && cpu_req) begin
                rw_q    <= cpu_rw;
                addr_q  <= cpu_addr[ADDR_W-1:2];
                wdata_q <= cpu_wdata;
            end
            if (launch) begin
                read_write_mem <= launch_rw;
                address_mem    <= launch_addr;
                if (launch_rw) write_data_mem <= r_data;
                word_cnt       <= word_n;
                wait_cnt       <= '0;
            end else if (wait_cnt != CW'(MEM_WAIT))
                wait_cnt <= wait_cnt + CW'(1);
        end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: scoreboarded bench with a word memory model reacting to address/rw changes
module tb_cache_controller;
    logic        clk = 1'b0, rst = 1'b1, cpu_req = 1'b0, cpu_rw = 1'b0, Done = 1'b1;
    logic [9:0]  cpu_addr = '0, address_mem;
    logic [31:0] cpu_wdata = '0, cpu_rdata, write_data_mem, read_data_mem;
    logic        cpu_done, read_write_mem;
    logic [31:0] mem [256];
    logic [10:0] prev = '0;
    int          checks = 0, errors = 0;

    typedef struct {logic rw; logic [9:0] a; logic [31:0] d;} mem_t;
    typedef struct {logic [31:0] rd; int lat; logic rw;} cpu_t;
    mem_t mem_q[$];
    cpu_t cpu_q[$];

    always #5 clk = ~clk;
    assign read_data_mem = mem[address_mem[9:2]];

    cache_controller dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .read_write_mem(read_write_mem), .address_mem(address_mem),
        .write_data_mem(write_data_mem), .read_data_mem(read_data_mem), .Done(Done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_mem(input logic rw, input logic [9:0] a, input logic [31:0] d);
        mem_q.push_back('{rw, a, d});
    endtask

    task automatic exp_fill(input logic [9:0] base);
        for (int k = 0; k < 4; k++) exp_mem(1'b0, base + 10'(4 * k), '0);
    endtask

    // memory acts on each change of {rw, address}; writes land immediately
    always @(negedge clk) begin : mon
        mem_t e;
        if (!rst && {read_write_mem, address_mem} != prev) begin
            if (mem_q.size() == 0)
                check("mem_idle", {read_write_mem, address_mem}, prev);
            else begin
                e = mem_q.pop_front();
                check("mem_rw", read_write_mem, e.rw);
                check("mem_addr", address_mem, e.a);
                if (e.rw) check("mem_wdata", write_data_mem, e.d);
            end
            if (read_write_mem) mem[address_mem[9:2]] = write_data_mem;
        end
        prev = {read_write_mem, address_mem};
    end

    task automatic cpu_op(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int lat);
        int   n = 1;
        cpu_t e;
        cpu_q.push_back('{rd, lat, rw});
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
            if (n == 2) begin cpu_addr = 10'($urandom); cpu_wdata = $urandom; end
        end while (!cpu_done && n < 200);
        e = cpu_q.pop_front();
        check("cpu_done", cpu_done, 1'b1);
        check("latency", n, e.lat);
        if (!e.rw) check("cpu_rdata", cpu_rdata, e.rd);
        @(posedge clk); #1 cpu_req = 1'b0;
    endtask

    initial begin
        #200000 $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'h5000_0000 + 32'(i * 4);
        mem[8'h10] = 32'h1111_1111; mem[8'h11] = 32'h2222_2222;
        mem[8'h12] = 32'h3333_3333; mem[8'h13] = 32'h4444_4444;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", cpu_done, 1'b0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_mem_rw", read_write_mem, 1'b0);
        check("rst_mem_addr", address_mem, 10'h0);
        check("rst_mem_wdata", write_data_mem, 32'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_fill(10'h040);
        cpu_op(1'b0, 10'h040, '0, 32'h1111_1111, 15);
        cpu_op(1'b0, 10'h048, '0, 32'h3333_3333, 2);
        cpu_op(1'b1, 10'h044, 32'hDEAD_BEEF, '0, 2);
        cpu_op(1'b0, 10'h044, '0, 32'hDEAD_BEEF, 2);
        check("mem_044_clean", mem[8'h11], 32'h2222_2222);
        exp_mem(1'b1, 10'h040, 32'h1111_1111); exp_mem(1'b1, 10'h044, 32'hDEAD_BEEF);
        exp_mem(1'b1, 10'h048, 32'h3333_3333); exp_mem(1'b1, 10'h04C, 32'h4444_4444);
        exp_fill(10'h140);
        cpu_op(1'b0, 10'h140, '0, 32'h5000_0140, 27);
        check("mem_044_wb", mem[8'h11], 32'hDEAD_BEEF);
        exp_fill(10'h200);
        cpu_op(1'b1, 10'h200, 32'hCAFE_F00D, '0, 15);
        check("mem_200_held", mem[8'h80], 32'h5000_0200);
        cpu_op(1'b0, 10'h200, '0, 32'hCAFE_F00D, 2);
        exp_fill(10'h050);
        cpu_op(1'b0, 10'h05C, '0, 32'h5000_005C, 15);
        Done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_fill(10'h060);
        fork
            cpu_op(1'b0, 10'h064, '0, 32'h5000_0064, 24);
            begin repeat (12) @(negedge clk); Done = 1'b1; end
        join
        exp_mem(1'b1, 10'h200, 32'hCAFE_F00D);
        exp_mem(1'b1, 10'h204, 32'h5000_0204);
        exp_mem(1'b1, 10'h208, 32'h5000_0208);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 10'h044;
        n = 0;
        do begin @(negedge clk); n++; end while (!(read_write_mem && address_mem == 10'h208) && n < 100);
        check("wb_third_seen", n < 100, 1'b1);
        #2 rst = 1'b1; cpu_req = 1'b0;
        #1;
        check("abort_done", cpu_done, 1'b0);
        check("abort_rdata", cpu_rdata, 32'h0);
        check("abort_mem_rw", read_write_mem, 1'b0);
        check("abort_mem_addr", address_mem, 10'h0);
        check("abort_mem_wdata", write_data_mem, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("mem_200_partial", mem[8'h80], 32'hCAFE_F00D);
        check("mem_20c_untouched", mem[8'h83], 32'h5000_020C);
        repeat (2) @(posedge clk);
        #1;
        exp_fill(10'h040);
        cpu_op(1'b0, 10'h044, '0, 32'hDEAD_BEEF, 15);
        repeat (4) @(posedge clk);
        check("mem_q_drained", mem_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
